// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

    // Responder states
    typedef enum logic [1:0] {
        IDLE,
        WAITST,
        RESP
    } memst_t;

    // Width of the wait-state counter; WAIT must fit in it (0..15).
    localparam int WAIT_W = 4;

endpackage

// File: rtl/ram_sp.sv
// Single-port word RAM, DEPTH x WIDTH. The write is synchronous. The read is
// asynchronous so the responder can capture the addressed word into its own
// output register on the same edge that completes the access. Read and write
// never coincide within one transaction. Contents are not reset.
module ram_sp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port. It accepts one word
// request over a req/ack handshake, waits WAIT cycles, then performs the read
// or write on the internal RAM and reports data/err with a one-cycle ack.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for req; request fields are latched on acceptance
//   WAITST | counting down the programmed wait states
//   RESP   | access done; ack/err/rdata presented for this one cycle
module dmem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ack,
    output logic             err,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    memst_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                bad_q, bad_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;

    logic                misalign;
    logic                out_of_range;
    logic [WIDTH-1:0]    word_addr;
    logic                access_now;
    logic                ram_we;
    logic [WIDTH-1:0]    ram_rdata;

    // Request checks: byte offset must be zero and the word index must fit
    always_comb begin
        word_addr    = addr >> 2;
        misalign     = (addr[1:0] != 2'b00);
        out_of_range = (word_addr >= WIDTH'(DEPTH));
    end

    // The access happens on the edge that moves WAITST into RESP; an
    // erroneous transaction never touches the array.
    assign access_now = (state_q == WAITST) && (cnt_q == '0);
    assign ram_we     = access_now && we_q && !bad_q;

    ram_sp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Next-state and next-output logic for the responder FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        bad_d   = bad_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAITST;
                    cnt_d   = WAIT_W'(WAIT);
                    we_d    = we;
                    idx_d   = addr[AW+1:2];
                    wdata_d = wdata;
                    bad_d   = misalign || out_of_range;
                end
            end
            WAITST: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    err_d   = bad_q;
                    rdata_d = (!we_q && !bad_q) ? ram_rdata : '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, request latches and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with WAIT=2 for the
// functional/error/reset cases and one with WAIT=0 for back-to-back traffic.
module tb_dmem_responder;

    localparam int WAIT2 = 2;
    localparam int WAIT0 = 0;

    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          at_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        req2, we2, ack2, err2, busy2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        req0, we0, ack0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q2[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT(WAIT2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .req   (req2),
        .we    (we2),
        .addr  (addr2),
        .wdata (wdata2),
        .rdata (rdata2),
        .ack   (ack2),
        .err   (err2),
        .busy  (busy2)
    );

    dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT(WAIT0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .we    (we0),
        .addr  (addr0),
        .wdata (wdata0),
        .rdata (rdata0),
        .ack   (ack0),
        .err   (err0),
        .busy  (busy0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm, input string what);
        n_vec++;
        n_bad++;
        $display("FAIL %s: %s (t=%0t)", nm, what, $time);
    endtask

    // Monitor for the WAIT=2 instance
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && ack2 === 1'b1) begin
            if (q2.size() == 0) begin
                bad("d2_unexpected_ack", "got ack=1 want no ack");
            end else begin
                e = q2.pop_front();
                chk("d2_rdata", rdata2, e.rd);
                chk("d2_err", 32'(err2), 32'(e.e));
                chk("d2_ack_cycle", 32'(cyc), 32'(e.at_cyc));
            end
        end
    end

    // Monitor for the WAIT=0 instance
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && ack0 === 1'b1) begin
            if (q0.size() == 0) begin
                bad("d0_unexpected_ack", "got ack=1 want no ack");
            end else begin
                e = q0.pop_front();
                chk("d0_rdata", rdata0, e.rd);
                chk("d0_err", 32'(err0), 32'(e.e));
                chk("d0_ack_cycle", 32'(cyc), 32'(e.at_cyc));
            end
        end
    end

    task automatic wait_idle2();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy2 !== 1'b0 && t < 50);
        if (busy2 !== 1'b0) bad("d2_idle_timeout", "got busy=1 want busy=0");
    endtask

    // One transaction on the WAIT=2 instance; hold=0 drops req after one cycle
    task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic ee, input bit hold);
        int   t;
        exp_t e;
        wait_idle2();
        req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
        e.rd = erd; e.e = ee; e.at_cyc = cyc + 1 + WAIT2 + 1;
        q2.push_back(e);
        t = 0;
        do begin
            @(negedge clk);
            t++;
            if (!hold) req2 = 1'b0;
        end while (ack2 !== 1'b1 && t < 20);
        if (ack2 !== 1'b1) bad("d2_ack_timeout", "got no ack want ack");
        req2 = 1'b0;
    endtask

    // Start a WAIT=2 transaction that will be cut by reset; returns at the
    // falling edge right after the accept edge (state WAITST, cnt=WAIT)
    task automatic start_raw2(input logic w, input logic [31:0] a, input logic [31:0] d);
        wait_idle2();
        req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
        @(negedge clk);
        req2 = 1'b0;
    endtask

    logic [31:0] b_addr [8];
    logic        b_we   [8];
    logic [31:0] b_data [8];

    initial begin
        int   k;
        int   t;
        exp_t e;

        reset = 1'b0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ack",   32'(ack2),  32'd0);
        chk("rst_err",   32'(err2),  32'd0);
        chk("rst_busy",  32'(busy2), 32'd0);
        chk("rst_rdata", rdata2,     32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);

        // write then read, ack at accept+3
        txn2(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        txn2(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        @(negedge clk);
        chk("rdata_hold", rdata2, 32'hDEADBEEF);
        chk("busy_low_after", 32'(busy2), 32'd0);

        // misaligned write is rejected and leaves memory alone
        txn2(1'b1, 32'h12, 32'h55555555, 32'h0, 1'b1, 1'b1);
        txn2(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // out-of-range accesses; 0x100 must not alias onto word 0
        txn2(1'b1, 32'h00, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        txn2(1'b1, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        txn2(1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1);
        txn2(1'b0, 32'h00, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);

        // last legal word
        txn2(1'b1, 32'hFC, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
        txn2(1'b0, 32'hFC, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);

        // single-cycle req pulse still completes
        txn2(1'b1, 32'h04, 32'h44444444, 32'h0, 1'b0, 1'b1);
        txn2(1'b0, 32'h04, 32'h0, 32'h44444444, 1'b0, 1'b0);

        // reset during WAITST drops the write
        txn2(1'b1, 32'h08, 32'h11111111, 32'h0, 1'b0, 1'b1);
        start_raw2(1'b1, 32'h08, 32'h12345678);
        chk("waitst_busy", 32'(busy2), 32'd1);
        reset = 1'b0;
        #1;
        chk("waitst_rst_busy", 32'(busy2), 32'd0);
        chk("waitst_rst_ack",  32'(ack2),  32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        txn2(1'b0, 32'h08, 32'h0, 32'h11111111, 1'b0, 1'b1);

        // reset during RESP clears ack at once; the write has happened
        start_raw2(1'b1, 32'h0C, 32'hCAFEF00D);
        repeat (WAIT2 + 1) @(posedge clk);
        #1;
        chk("resp_ack_high", 32'(ack2), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("resp_rst_ack",  32'(ack2),  32'd0);
        chk("resp_rst_busy", 32'(busy2), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        txn2(1'b0, 32'h0C, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

        // WAIT=0 back-to-back with req held: accept, RESP, IDLE, accept ...
        // so each transaction takes 3 cycles and acks are 3 cycles apart.
        b_addr = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h00, 32'h04, 32'h08, 32'h0C};
        b_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        b_data = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404,
                   32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        @(negedge clk);
        k = cyc + 1;
        req0 = 1'b1; we0 = b_we[0]; addr0 = b_addr[0]; wdata0 = b_data[0];
        for (int i = 0; i < 8; i++) begin
            e.rd = b_we[i] ? 32'h0 : b_data[i];
            e.e = 1'b0;
            e.at_cyc = k + 3 * i + WAIT0 + 1;
            q0.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (ack0 !== 1'b1 && t < 20);
            if (ack0 !== 1'b1) bad("d0_ack_timeout", "got no ack want ack");
            if (i < 7) begin
                we0 = b_we[i + 1]; addr0 = b_addr[i + 1]; wdata0 = b_data[i + 1];
            end else begin
                req0 = 1'b0;
            end
        end

        repeat (6) @(negedge clk);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
